array_ctrl_32x228: RTL and testbench
====================================

ARRAY_CTRL_32X228 -- requirements
Module: array_ctrl_32x228

Interface
REQ-001 Parameter ENTRIES, 32, SRAM depth; address width log2(ENTRIES)=5 SHALL be used.
REQ-002 Parameter WIDTH, 228, data width.
REQ-003 Parameter WAYS, 2, write-mask granularity; each way is WIDTH/WAYS=114 bits.
REQ-004 Parameter STARVE_LIMIT, 4, consecutive blocked read cycles before the read wins arbitration.
REQ-005 clock  in  1  sole clock; all state on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 r_valid  in  1  read request valid.
REQ-008 r_ready  out  1  read request accepted when r_valid&&r_ready.
REQ-009 r_addr  in  5  read entry index.
REQ-010 r_resp_valid  out  1  one-cycle pulse: read data valid.
REQ-011 r_resp_data  out  228  read data; held stable between pulses.
REQ-012 w_valid  in  1  write request valid.
REQ-013 w_ready  out  1  write accepted when w_valid&&w_ready.
REQ-014 w_addr  in  5  write entry index.
REQ-015 w_mask  in  2  per-way write enable; bit i covers data[i*114 +: 114].
REQ-016 w_data  in  228  write data.
REQ-017 init_done  out  1  high once the reset clearing sweep completes.
REQ-018 sram_en, sram_wmode  out  1 each  single-port SRAM enable and write mode (1=write).
REQ-019 sram_addr  out  5; sram_wmask  out  2; sram_wdata  out  228  SRAM command fields.
REQ-020 sram_rdata  in  228  SRAM read data, valid the cycle after a read command.

Function
REQ-021 SRAM command outputs SHALL be combinational from the current-cycle grant; at most one SRAM access per cycle.
REQ-022 FSM states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-023 INIT: each cycle drive sram_en=1, sram_wmode=1, sram_wmask=2'b11, sram_wdata=0, sram_addr=counter; counter increments; after addr 31 is written, next state RUN.
REQ-024 INIT lasts exactly 32 cycles after reset release; init_done, r_ready, w_ready SHALL be 0 throughout INIT.
REQ-025 RUN: init_done=1; w_ready=1 unless starvation override active; r_ready=1 unless w_valid and no override.
REQ-026 Write with w_mask=0 SHALL still be accepted (handshake completes) with sram_en=0 for that cycle.
REQ-027 Starvation counter increments each RUN cycle r_valid=1 and read not granted; clears on read grant or r_valid=0; saturates at STARVE_LIMIT.
REQ-028 When counter==STARVE_LIMIT: override active, r_ready=1, w_ready=0 that cycle.
REQ-029 Accepted read in cycle N: sram_en=1, sram_wmode=0, sram_addr=r_addr; r_resp_valid=1 in cycle N+1 with r_resp_data=sram_rdata.
REQ-030 r_resp_data SHALL be captured into a hold register on every r_resp_valid cycle and driven from it otherwise.
REQ-031 Back-to-back reads every cycle SHALL give back-to-back responses, in order, one per cycle.
REQ-032 Write in cycle N+1 to the address read in cycle N SHALL not affect the cycle-N+1 response (old data returned).
REQ-033 Read accepted the cycle after a write to the same address SHALL return the new data (SRAM write completes in cycle).

Reset
REQ-034 On reset_n=0, immediately: r_resp_valid=0, r_resp_data=0, init_done=0, r_ready=0, w_ready=0, sram_en=0, starvation counter=0, FSM=INIT, sweep counter=0.
REQ-035 Reset mid-sweep or mid-read SHALL abort: pending response dropped, sweep restarts from address 0 after release.

Verification
REQ-036 Release reset, idle -> sram writes addr 0..31 with data 0, mask 3 in 32 consecutive cycles; init_done rises cycle 32.
REQ-037 After init, write addr 5 mask 2'b01 data all-ones, then read addr 5 -> r_resp_valid next cycle, data low 114 bits ones, high 114 bits zero.
REQ-038 w_valid and r_valid held high continuously -> writes win 4 cycles, read granted on 5th cycle, pattern repeats.
REQ-039 Reads to addr 0,1,2 on consecutive cycles -> three consecutive resp pulses in order; r_resp_data then stable while idle.
REQ-040 Assert reset_n=0 at sweep addr 10 -> outputs zero immediately; after release sweep restarts at 0, init_done after 32 cycles.
REQ-041 Read in INIT (r_valid=1) -> r_ready=0, no SRAM read, no response until RUN.

Source files
------------

// File: rtl/array_ctrl_32x228.sv
// Single-port SRAM controller: reset clearing sweep, write-priority
// arbitration with read starvation override, and held read response.
module array_ctrl_32x228 #(
    parameter int ENTRIES      = 32,
    parameter int WIDTH        = 228,
    parameter int WAYS         = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       r_valid,
    output logic                       r_ready,
    input  logic [$clog2(ENTRIES)-1:0] r_addr,
    output logic                       r_resp_valid,
    output logic [WIDTH-1:0]           r_resp_data,
    input  logic                       w_valid,
    output logic                       w_ready,
    input  logic [$clog2(ENTRIES)-1:0] w_addr,
    input  logic [WAYS-1:0]            w_mask,
    input  logic [WIDTH-1:0]           w_data,
    output logic                       init_done,
    output logic                       sram_en,
    output logic                       sram_wmode,
    output logic [$clog2(ENTRIES)-1:0] sram_addr,
    output logic [WAYS-1:0]            sram_wmask,
    output logic [WIDTH-1:0]           sram_wdata,
    input  logic [WIDTH-1:0]           sram_rdata
);

    localparam int AW = $clog2(ENTRIES);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {
        S_INIT,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   sweep_q, sweep_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            resp_valid_q;
    logic [WIDTH-1:0] hold_q;
    logic            override;
    logic            r_fire;
    logic            w_fire;

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        starve_d   = '0;
        override   = 1'b0;
        r_fire     = 1'b0;
        w_fire     = 1'b0;
        r_ready    = 1'b0;
        w_ready    = 1'b0;
        sram_en    = 1'b0;
        sram_wmode = 1'b0;
        sram_addr  = '0;
        sram_wmask = '0;
        sram_wdata = '0;
        unique case (state_q)
            S_INIT: begin
                // State snaps to INIT on async reset; gate so the bus is idle
                sram_en    = reset_n;
                sram_wmode = 1'b1;
                sram_wmask = '1;
                sram_addr  = sweep_q;
                sweep_d    = sweep_q + AW'(1);
                if (sweep_q == AW'(ENTRIES - 1)) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                override = (starve_q == SW'(STARVE_LIMIT));
                w_ready  = !override;
                r_ready  = override || !w_valid;
                w_fire   = w_valid && !override;
                r_fire   = r_valid && (override || !w_valid);
                if (w_fire) begin
                    sram_en    = |w_mask;
                    sram_wmode = 1'b1;
                    sram_addr  = w_addr;
                    sram_wmask = w_mask;
                    sram_wdata = w_data;
                end else if (r_fire) begin
                    sram_en   = 1'b1;
                    sram_addr = r_addr;
                end
                if (r_valid && !r_fire) begin
                    starve_d = override ? starve_q : starve_q + SW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_INIT;
            sweep_q      <= '0;
            starve_q     <= '0;
            resp_valid_q <= 1'b0;
            hold_q       <= '0;
        end else begin
            state_q      <= state_d;
            sweep_q      <= sweep_d;
            starve_q     <= starve_d;
            resp_valid_q <= r_fire;
            if (resp_valid_q) begin
                hold_q <= sram_rdata;
            end
        end
    end

    assign r_resp_valid = resp_valid_q;
    assign r_resp_data  = resp_valid_q ? sram_rdata : hold_q;
    assign init_done    = (state_q == S_RUN);

endmodule

// File: tb/tb_array_ctrl_32x228.sv
// Directed bench for array_ctrl_32x228 with an SRAM stand-in and an
// abstract memory/arbitration model checked every cycle.
module tb_array_ctrl_32x228;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         r_valid;
    logic         r_ready;
    logic [4:0]   r_addr;
    logic         r_resp_valid;
    logic [227:0] r_resp_data;
    logic         w_valid;
    logic         w_ready;
    logic [4:0]   w_addr;
    logic [1:0]   w_mask;
    logic [227:0] w_data;
    logic         init_done;
    logic         sram_en;
    logic         sram_wmode;
    logic [4:0]   sram_addr;
    logic [1:0]   sram_wmask;
    logic [227:0] sram_wdata;
    logic [227:0] sram_rdata = '0;

    int tests = 0;
    int fails = 0;

    array_ctrl_32x228 dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .r_valid      (r_valid),
        .r_ready      (r_ready),
        .r_addr       (r_addr),
        .r_resp_valid (r_resp_valid),
        .r_resp_data  (r_resp_data),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_addr       (w_addr),
        .w_mask       (w_mask),
        .w_data       (w_data),
        .init_done    (init_done),
        .sram_en      (sram_en),
        .sram_wmode   (sram_wmode),
        .sram_addr    (sram_addr),
        .sram_wmask   (sram_wmask),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata)
    );

    always #5 clock = ~clock;

    // SRAM stand-in: registered read, masked write; contents survive reset
    logic [227:0] sram_mem [32];
    initial begin
        for (int i = 0; i < 32; i++) begin
            sram_mem[i] = {$urandom, $urandom, $urandom, $urandom,
                           $urandom, $urandom, $urandom, 4'hF};
        end
    end

    always @(posedge clock) begin
        if (sram_en) begin
            if (sram_wmode) begin
                for (int w = 0; w < 2; w++) begin
                    if (sram_wmask[w]) begin
                        sram_mem[sram_addr][w*114 +: 114] <= sram_wdata[w*114 +: 114];
                    end
                end
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    task automatic chk(input string nm, input logic [227:0] act,
                       input logic [227:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    // Abstract model: memory contents, cycles since reset release,
    // consecutive blocked reads, and the response in flight.
    logic [227:0] mdl [32];
    int           since_rel = 0;
    int           blk = 0;
    logic         pend = 1'b0;
    logic [227:0] pend_d = '0;
    logic [227:0] hold_d = '0;
    logic         ov, wf, rf, wr_en;

    always @(negedge clock) begin
        if (!reset_n) begin
            chk("rst_resp_valid", r_resp_valid, 0);
            chk("rst_resp_data", r_resp_data, 0);
            chk("rst_init_done", init_done, 0);
            chk("rst_r_ready", r_ready, 0);
            chk("rst_w_ready", w_ready, 0);
            chk("rst_sram_en", sram_en, 0);
            since_rel = 0;
            blk = 0;
            pend = 1'b0;
            hold_d = '0;
        end else begin
            chk("resp_valid", r_resp_valid, pend);
            chk("resp_data", r_resp_data, pend ? pend_d : hold_d);
            if (pend) hold_d = pend_d;
            if (since_rel < 32) begin
                chk("init_en", sram_en, 1);
                chk("init_wmode", sram_wmode, 1);
                chk("init_wmask", sram_wmask, 2'b11);
                chk("init_wdata", sram_wdata, 0);
                chk("init_addr", sram_addr, since_rel[4:0]);
                chk("init_done_lo", init_done, 0);
                chk("init_r_ready", r_ready, 0);
                chk("init_w_ready", w_ready, 0);
                mdl[since_rel] = '0;
                since_rel++;
                pend = 1'b0;
                blk = 0;
            end else begin
                ov = (blk >= 4);
                wf = w_valid && !ov;
                rf = r_valid && (ov || !w_valid);
                wr_en = wf && (w_mask != 2'b00);
                chk("run_init_done", init_done, 1);
                chk("run_w_ready", w_ready, !ov);
                chk("run_r_ready", r_ready, ov || !w_valid);
                chk("run_sram_en", sram_en, wr_en || rf);
                if (wr_en) begin
                    chk("wr_wmode", sram_wmode, 1);
                    chk("wr_addr", sram_addr, w_addr);
                    chk("wr_wmask", sram_wmask, w_mask);
                    chk("wr_wdata", sram_wdata, w_data);
                end else if (rf) begin
                    chk("rd_wmode", sram_wmode, 0);
                    chk("rd_addr", sram_addr, r_addr);
                end
                pend = rf;
                if (rf) pend_d = mdl[r_addr];
                if (wf) begin
                    for (int w = 0; w < 2; w++) begin
                        if (w_mask[w]) mdl[w_addr][w*114 +: 114] = w_data[w*114 +: 114];
                    end
                end
                blk = (rf || !r_valid) ? 0 : ((blk < 4) ? blk + 1 : 4);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_in(input logic rv, input logic [4:0] ra,
                          input logic wv, input logic [4:0] wa,
                          input logic [1:0] wm, input logic [227:0] wd);
        r_valid = rv;
        r_addr  = ra;
        w_valid = wv;
        w_addr  = wa;
        w_mask  = wm;
        w_data  = wd;
    endtask

    task automatic wait_init(output int k, output int pulses);
        k = 0;
        pulses = 0;
        while (k < 40) begin
            @(negedge clock);
            if (init_done) break;
            if (r_resp_valid) pulses++;
            k++;
        end
    endtask

    logic [227:0] ones = '1;
    logic [227:0] lo_ones = {{114{1'b0}}, {114{1'b1}}};
    logic [227:0] d0 = {114'd3, 114'd5};
    logic [227:0] d1 = {114'h2AAA, 114'h1555};
    logic [227:0] d2 = {114'd77, 114'h3FFF_FFFF};
    logic         pat [15];
    int           cyc, npulse;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, '0);
        repeat (3) step();

        // Release with a read pending during the sweep
        reset_n = 1'b1;
        set_in(1, 5'd3, 0, 0, 0, '0);
        wait_init(cyc, npulse);
        chk("init_len", cyc, 32);
        chk("init_no_resp", npulse, 0);

        // Half-way write then read-after-write to the same entry
        step();
        set_in(0, 0, 1, 5'd5, 2'b01, ones);
        step();
        set_in(1, 5'd5, 0, 0, 0, '0);
        step();
        set_in(0, 0, 0, 0, 0, '0);
        @(negedge clock);
        chk("raw_valid", r_resp_valid, 1);
        chk("raw_data", r_resp_data, lo_ones);

        // Zero-mask write, then read followed by overlapping write
        step();
        set_in(0, 0, 1, 5'd6, 2'b00, ones);
        step();
        set_in(1, 5'd6, 0, 0, 0, '0);
        step();
        set_in(1, 5'd5, 0, 0, 0, '0);
        step();
        set_in(0, 0, 1, 5'd5, 2'b11, d1);
        @(negedge clock);
        chk("war_valid", r_resp_valid, 1);
        chk("war_old_data", r_resp_data, lo_ones);

        // Back-to-back reads
        step();
        set_in(0, 0, 1, 5'd0, 2'b11, d0);
        step();
        set_in(0, 0, 1, 5'd1, 2'b11, d1);
        step();
        set_in(0, 0, 1, 5'd2, 2'b11, d2);
        step();
        set_in(1, 5'd0, 0, 0, 0, '0);
        step();
        set_in(1, 5'd1, 0, 0, 0, '0);
        @(negedge clock);
        chk("b2b_0", r_resp_data, d0);
        step();
        set_in(1, 5'd2, 0, 0, 0, '0);
        @(negedge clock);
        chk("b2b_1", r_resp_data, d1);
        step();
        set_in(0, 0, 0, 0, 0, '0);
        @(negedge clock);
        chk("b2b_2", r_resp_data, d2);
        step();
        step();
        @(negedge clock);
        chk("idle_valid", r_resp_valid, 0);
        chk("idle_hold", r_resp_data, d2);

        // Contention: four writes then the starved read
        for (int i = 0; i < 15; i++) begin
            step();
            set_in(1, 5'd0, 1, 5'(i + 8), 2'b11, 228'(i));
            @(negedge clock);
            pat[i] = w_ready;
        end
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("starve_pat%0d", i), pat[i], (i % 5) != 4);
        end

        // Reset in the middle of the sweep
        step();
        set_in(0, 0, 0, 0, 0, '0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        repeat (10) @(posedge clock);
        #2;
        chk("sweep_at10", sram_addr, 5'd10);
        reset_n = 1'b0;
        #1;
        chk("async_en", sram_en, 0);
        chk("async_done", init_done, 0);
        chk("async_rrdy", r_ready, 0);
        chk("async_wrdy", w_ready, 0);
        step();
        reset_n = 1'b1;
        wait_init(cyc, npulse);
        chk("reinit_len", cyc, 32);

        // Reset while a response is due
        step();
        set_in(1, 5'd1, 0, 0, 0, '0);
        step();
        set_in(0, 0, 0, 0, 0, '0);
        reset_n = 1'b0;
        #1;
        chk("drop_valid", r_resp_valid, 0);
        chk("drop_data", r_resp_data, 0);
        step();
        reset_n = 1'b1;
        wait_init(cyc, npulse);
        chk("final_init_len", cyc, 32);
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
